// File: rtl/iomem_timer.sv
// Purpose : iomem-bus target holding a prescaled 32-bit down counter with reload and a level irq.
// Latency : a request is accepted on the edge it is seen in IDLE; ready/rdata are registered for one cycle.
// Backpressure: none. One transaction every two cycles; off-page addresses are never acknowledged.
//
// Ports:
//   clk, reset                       - single clock, async active-high reset
//   iomem_valid/wstrb/addr/wdata     - request from the initiator (wstrb==0 is a read)
//   iomem_ready/iomem_rdata          - one-cycle acknowledge, read data valid only with ready
//   irq                              - registered expired & irq_en
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t      state_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    logic [2:0]  ctrl_q,     ctrl_d;      // {irq_en, auto, en}
    logic [31:0] load_q,     load_d;
    logic [31:0] count_q,    count_d;
    logic        expired_q,  expired_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q,     pcnt_d;
    logic        irq_q,      irq_d;

    logic        hit, accept, wr, tick, expire_set;
    logic [5:0]  off;
    logic [31:0] rd_mux, rdata_d;

    // Byte lanes [1:0] of the address carry no information for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^iomem_addr[1:0];

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] nxt,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        hit    = (iomem_addr[31:8] == BASE_ADDR[31:8]);
        accept = (state_q == S_IDLE) && iomem_valid && hit;
        wr     = accept && (iomem_wstrb != 4'b0000);
        off    = iomem_addr[7:2];
        tick   = ctrl_q[0] && (pcnt_q == prescale_q);

        // Read mux sees pre-update state, so reads never observe a same-edge tick.
        case (off)
            6'h00:   rd_mux = {29'b0, ctrl_q};
            6'h01:   rd_mux = load_q;
            6'h02:   rd_mux = count_q;
            6'h03:   rd_mux = {31'b0, expired_q};
            6'h04:   rd_mux = {16'b0, prescale_q};
            default: rd_mux = 32'b0;
        endcase
        rdata_d = (accept && !wr) ? rd_mux : 32'b0;

        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;
        prescale_d = prescale_q;
        expire_set = 1'b0;

        // Prescaler wraps on tick and is parked at 0 while disabled.
        pcnt_d = (ctrl_q[0] && !tick) ? pcnt_q + 16'd1 : 16'd0;

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expire_set = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        // Bus writes are applied after hardware updates so they win on collision.
        if (wr) begin
            case (off)
                6'h00: if (iomem_wstrb[0]) ctrl_d = iomem_wdata[2:0];
                6'h01: load_d  = byte_merge(load_q,  iomem_wdata, iomem_wstrb);
                6'h02: count_d = byte_merge(count_q, iomem_wdata, iomem_wstrb);
                6'h03: if (iomem_wstrb[0] && iomem_wdata[0]) expired_d = 1'b0;
                6'h04: begin
                    if (iomem_wstrb[0]) prescale_d[7:0]  = iomem_wdata[7:0];
                    if (iomem_wstrb[1]) prescale_d[15:8] = iomem_wdata[15:8];
                end
                default: ;
            endcase
        end

        // Hardware expiry outranks a software clear on the same edge.
        if (expire_set) begin
            expired_d = 1'b1;
        end

        irq_d = expired_q & ctrl_q[2];
    end

    // Bus FSM with registered ready/rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_q <= S_ACK;
                S_ACK:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            ready_q <= accept;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= 3'b0;
            load_q     <= 32'b0;
            count_q    <= 32'b0;
            expired_q  <= 1'b0;
            prescale_q <= 16'b0;
            pcnt_q     <= 16'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            irq_q      <= irq_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_timer.sv
module tb_iomem_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_LOAD = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_PRE  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    iomem_timer #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Drives one request and waits (bounded) for ready. Called 1ns after a rising edge;
    // returns 1ns after the accept edge with valid already dropped.
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                       output logic [31:0] rd, output bit acked);
        int n;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
        iomem_valid = 1'b1;
        acked = 1'b0;
        rd = 32'b0;
        n = 0;
        while (!acked && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (iomem_ready) begin
                acked = 1'b1;
                rd = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        bit a;
        bus(addr, 4'hF, data, d, a);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        bit a;
        reset = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        iomem_addr = 32'b0;
        iomem_wdata = 32'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({iomem_ready, iomem_rdata, irq} !== 34'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b, expected all 0", iomem_ready, iomem_rdata, irq);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        // First read done by hand to check the one-cycle ready pulse.
        iomem_addr = A_CTRL;
        iomem_valid = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (iomem_ready !== 1'b1 || iomem_rdata !== 32'b0) begin
            miscompares++;
            $display("FAIL first_ready: got ready=%b rdata=%h, expected ready=1 rdata=0", iomem_ready, iomem_rdata);
        end
        iomem_valid = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (iomem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_width: got ready=%b one cycle later, expected 0", iomem_ready);
        end
        for (int i = 0; i < 5; i++) begin
            bus(BASE + 32'(4 * i), 4'h0, 32'b0, r, a);
            vectors++;
            if (!a || r !== 32'b0) begin
                miscompares++;
                $display("FAIL reset_reg[%0d]: got acked=%b data=%h, expected acked=1 data=0", i, a, r);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] r;
        bit a;
        bus(A_LOAD, 4'b0011, 32'h1234_5678, r, a);
        bus(A_LOAD, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'h0000_5678) begin
            miscompares++;
            $display("FAIL load_strobe: got %h expected 00005678", r);
        end
        wr(A_PRE, 32'hFFFF_FFFF);
        bus(A_PRE, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'h0000_FFFF) begin
            miscompares++;
            $display("FAIL prescale_width: got %h expected 0000ffff", r);
        end
        wr(A_PRE, 32'h0);
        wr(BASE + 32'h20, 32'hFFFF_FFFF);
        bus(BASE + 32'h20, 4'h0, 32'b0, r, a);
        vectors++;
        if (!a || r !== 32'b0) begin
            miscompares++;
            $display("FAIL unmapped_in_page: got acked=%b data=%h, expected acked=1 data=0", a, r);
        end
        bus(BASE + 32'h100, 4'h0, 32'b0, r, a);
        vectors++;
        if (a) begin
            miscompares++;
            $display("FAIL off_page: got acked=1, expected no ready within 20 cycles");
        end
    endtask

    task automatic test_back_to_back();
        iomem_addr = A_LOAD;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (iomem_ready !== 1'b1 || iomem_rdata !== 32'h0000_5678) begin
            miscompares++;
            $display("FAIL b2b_first: got ready=%b rdata=%h, expected 1/00005678", iomem_ready, iomem_rdata);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got ready=%b rdata=%h, expected 0/00000000", iomem_ready, iomem_rdata);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (iomem_ready !== 1'b1 || iomem_rdata !== 32'h0000_5678) begin
            miscompares++;
            $display("FAIL b2b_second: got ready=%b rdata=%h, expected 1/00005678", iomem_ready, iomem_rdata);
        end
        iomem_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_periodic();
        logic [31:0] r;
        bit a;
        wr(A_STAT, 32'h1);
        wr(A_PRE, 32'd3);
        wr(A_LOAD, 32'd4);
        wr(A_CNT, 32'd4);
        wr(A_CTRL, 32'h7);              // accept edge E
        repeat (19) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL periodic_irq_early1: got irq=%b at E+19, expected 0", irq);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL periodic_irq_rise1: got irq=%b at E+21, expected 1", irq);
        end
        bus(A_CNT, 4'h0, 32'b0, r, a);  // accepted at E+22
        vectors++;
        if (r !== 32'd4) begin
            miscompares++;
            $display("FAIL periodic_reload1: got %0d expected 4", r);
        end
        wr(A_STAT, 32'h1);              // accepted at E+24
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL periodic_w1c: got irq=%b at E+26, expected 0", irq);
        end
        repeat (13) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL periodic_irq_early2: got irq=%b at E+39, expected 0", irq);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL periodic_irq_rise2: got irq=%b at E+41, expected 1", irq);
        end
        bus(A_CNT, 4'h0, 32'b0, r, a);  // accepted at E+42
        vectors++;
        if (r !== 32'd4) begin
            miscompares++;
            $display("FAIL periodic_reload2: got %0d expected 4", r);
        end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
    endtask

    task automatic test_oneshot();
        logic [31:0] r;
        bit a;
        wr(A_PRE, 32'd0);
        wr(A_CNT, 32'd2);
        wr(A_CTRL, 32'h5);              // accept edge E; expiry at E+3
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_irq_early: got irq=%b at E+2, expected 0", irq);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_irq: got irq=%b at E+4, expected 1", irq);
        end
        bus(A_CTRL, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'h4) begin
            miscompares++;
            $display("FAIL oneshot_en_clear: got ctrl=%h expected 00000004", r);
        end
        repeat (5) @(posedge clk);
        #1;
        bus(A_CNT, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'd0) begin
            miscompares++;
            $display("FAIL oneshot_count_hold: got %0d expected 0", r);
        end
        bus(A_STAT, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'h1) begin
            miscompares++;
            $display("FAIL oneshot_status: got %h expected 00000001", r);
        end
        wr(A_STAT, 32'h0);              // writing 0 must not clear
        bus(A_STAT, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'h1) begin
            miscompares++;
            $display("FAIL status_w0: got %h expected 00000001", r);
        end
        wr(A_STAT, 32'h1);              // accept edge W
        @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_irq_drop: got irq=%b at W+1, expected 0", irq);
        end
    endtask

    task automatic test_collisions();
        logic [31:0] r;
        bit a;
        // W1C on the expiry edge: expiry must win.
        wr(A_CNT, 32'd5);
        wr(A_CTRL, 32'h5);              // accept E; prescale 0 -> expiry at E+6
        repeat (5) @(posedge clk);
        #1;
        wr(A_STAT, 32'h1);              // accepted at E+6
        bus(A_STAT, 4'h0, 32'b0, r, a);
        vectors++;
        if (r !== 32'h1) begin
            miscompares++;
            $display("FAIL collide_w1c: got status=%h expected 00000001", r);
        end
        wr(A_STAT, 32'h1);
        // COUNT write on a tick edge: write must win.
        wr(A_PRE, 32'd3);
        wr(A_LOAD, 32'd1000);
        wr(A_CNT, 32'd1000);
        wr(A_CTRL, 32'h3);              // accept E; ticks at E+4, E+8
        repeat (3) @(posedge clk);
        #1;
        wr(A_CNT, 32'd100);             // accepted at E+4
        bus(A_CNT, 4'h0, 32'b0, r, a);  // accepted at E+6
        vectors++;
        if (r !== 32'd100) begin
            miscompares++;
            $display("FAIL collide_count: got %0d expected 100", r);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bit a;
        iomem_addr = A_LOAD;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hDEAD_BEEF;
        iomem_valid = 1'b1;
        @(posedge clk);
        #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (iomem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ready: got ready=%b expected 0", iomem_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus(A_LOAD, 4'h0, 32'b0, r, a);
        vectors++;
        if (!a || r !== 32'b0) begin
            miscompares++;
            $display("FAIL reset_mid_load: got acked=%b data=%h, expected acked=1 data=0", a, r);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_back_to_back();
        test_periodic();
        test_oneshot();
        test_collisions();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped down-counting timer that responds to the SoC's iomem bus as a target and drives one of the CPU's external interrupt lines. It accepts the CPU-side iomem transaction (valid/ready with byte strobes), holds a prescaled 32-bit down counter with reload, and raises a level interrupt on expiry. It is the responder at the far end of the iomem interface the picoRV32 SoC initiates, and its `irq` output feeds an `irq_5`..`irq_7` input.

## Interface
- `BASE_ADDR`, default 32'h0300_0000: base address. Decode compares `iomem_addr[31:8]` with `BASE_ADDR[31:8]`.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `iomem_valid`  input  1  request from the initiator. Held high until `iomem_ready` is sampled.
- `iomem_wstrb`  input  4  byte write strobes. 0 means read.
- `iomem_addr`  input  32  byte address. Word aligned; bits [1:0] are ignored.
- `iomem_wdata`  input  32  write data.
- `iomem_ready`  output  1  one-cycle acknowledge.
- `iomem_rdata`  output  32  read data. Valid only while `iomem_ready`=1, and 0 otherwise.
- `irq`  output  1  registered level interrupt: `expired & CTRL.irq_en`.

## Operation
- Register map (offset from base):
  - 0x00 CTRL: bit0 `en`, bit1 `auto`, bit2 `irq_en`. Other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: 32-bit current count. Reads return the live value; writes load it.
  - 0x0C STATUS: bit0 `expired`. Writing 1 clears it (W1C); writing 0 has no effect.
  - 0x10 PRESCALE: bits [15:0]. Upper bits read 0.
  - Offsets 0x14–0xFC: acknowledged. Reads return 0 and writes are ignored.
- Addresses outside the base page are never acknowledged. Another target owns them.
- Bus FSM has two states, IDLE and ACK:
  - IDLE → ACK when `iomem_valid` is high and the address decodes. The write takes effect or read data is captured on this accept edge.
  - ACK → IDLE unconditionally. `iomem_ready`=1 only in ACK.
- Writes apply per byte lane according to `iomem_wstrb`. For STATUS, the W1C applies only to lane 0.
- Prescaler: a 16-bit counter `pcnt` runs while `en`=1.
  - `tick` is asserted when `pcnt==PRESCALE`; `pcnt` then wraps to 0.
  - While `en`=0, `pcnt` is held at 0.
- On each `tick`:
  - If COUNT≠0: COUNT decrements by 1.
  - If COUNT==0: `expired` is set. If `auto`=1, COUNT loads LOAD. Otherwise `en` clears and COUNT stays 0.
- Precedence when events coincide on the same edge:
  - A bus write to COUNT beats the tick decrement or reload.
  - A hardware `expired` set beats a software W1C clear.
  - A bus write to CTRL beats the hardware clear of `en`.
- Counter arithmetic is unsigned 32-bit. There is no wrap below 0.

## Timing
- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `irq`=0; CTRL, LOAD, COUNT, STATUS, PRESCALE and `pcnt` all 0; FSM in IDLE.
- Bus latency:
  - `valid` sampled at edge N → `ready` high from N to N+1 → back to IDLE at N+1.
  - Back-to-back requests are accepted one edge later, giving one transaction every 2 cycles.
- Read data reflects register state before any same-edge hardware update.
- Tick period is PRESCALE+1 cycles after `en` rises.
- With `auto`=1 and LOAD=L, `expired` sets every (L+1)·(PRESCALE+1) cycles.
- `irq` follows `expired & irq_en` with one register stage.
- Reset asserted mid-transaction forces IDLE and drops `ready` immediately (asynchronous). No partial write survives.

## Test plan
- Reset, then read each register at 0x00–0x10 → all return 0. Each `ready` pulse lasts exactly 1 cycle, one cycle after `valid`.
- Write LOAD=0x1234_5678 with wstrb=4'b0011, then read LOAD → 0x0000_5678. A read at base+0x20 → 0, acknowledged. A read at BASE+0x100 → `ready` never asserts within 20 cycles.
- PRESCALE=3, LOAD=4, COUNT=4, CTRL=0b111 → `expired` and `irq` rise 20 cycles after the enable write, and again every 20 cycles. COUNT reads 4 right after each expiry.
- One-shot: CTRL=0b101, COUNT=2, PRESCALE=0 → expiry after 3 cycles. `en` reads 0 and COUNT stays 0 afterward. W1C of STATUS drops `irq` one cycle later.
- Collision: time a STATUS W1C onto the same edge as an expiry → `expired` stays 1. Time a COUNT=100 write onto a tick edge → COUNT reads 100.
- Assert `reset` during the ACK cycle of a write → `ready` drops immediately and the written register reads 0 after release.
